// File: rtl/xpb_pkg.sv
// Shared parameters, FSM state constants and width helpers for the xpb accumulator.
package xpb_pkg;

    localparam int XPB_DATA_W    = 1024;
    localparam int XPB_NUM_TERMS = 32;
    localparam int XPB_SEG_W     = 128;

    typedef logic [1:0] xpb_state_t;

    localparam xpb_state_t ST_IDLE    = 2'd0;
    localparam xpb_state_t ST_ACCUM   = 2'd1;
    localparam xpb_state_t ST_RESOLVE = 2'd2;
    localparam xpb_state_t ST_DONE    = 2'd3;

    function automatic int xpb_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int xpb_out_w(input int data_w, input int num_terms);
        return data_w + xpb_clog2(num_terms);
    endfunction

    function automatic int xpb_nseg(input int out_w, input int seg_w);
        return (out_w + seg_w - 1) / seg_w;
    endfunction

endpackage

// File: rtl/xpb_csa32.sv
// 3:2 carry-save compressor; the carry vector comes out already shifted up by one bit.
module xpb_csa32
    import xpb_pkg::*;
#(
    parameter int W = xpb_out_w(XPB_DATA_W, XPB_NUM_TERMS)
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    assign sum = a ^ b ^ c;

    // The MSB majority would shift out of range, so it is never formed.
    assign carry = {(a[W-2:0] & b[W-2:0]) | (a[W-2:0] & c[W-2:0]) | (b[W-2:0] & c[W-2:0]), 1'b0};

endmodule

// File: rtl/xpb_accum.sv
// Accumulates NUM_TERMS xpb terms in carry-save form, then resolves the sum SEG_W bits per cycle.
//   state   | meaning
//   IDLE    | waiting for start, last result still on out_data
//   ACCUM   | in_ready high, one CSA step per accepted term
//   RESOLVE | segmented carry-propagate add, one segment per cycle
//   DONE    | out_valid high until out_ready
module xpb_accum
    import xpb_pkg::*;
#(
    parameter int DATA_W    = XPB_DATA_W,
    parameter int NUM_TERMS = XPB_NUM_TERMS,
    parameter int SEG_W     = XPB_SEG_W,
    localparam int CNT_W    = xpb_clog2(NUM_TERMS + 1),
    localparam int OUT_W    = xpb_out_w(DATA_W, NUM_TERMS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  term_cnt
);

    localparam int NSEG   = xpb_nseg(OUT_W, SEG_W);
    localparam int PAD_W  = NSEG * SEG_W;
    localparam int SIDX_W = (NSEG > 1) ? xpb_clog2(NSEG) : 1;

    xpb_state_t        state_q, state_d;
    logic [OUT_W-1:0]  s_q, s_d, c_q, c_d, out_q, out_d;
    logic              carry_q, carry_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SIDX_W-1:0] seg_q, seg_d;

    logic [OUT_W-1:0]  csa_sum, csa_carry;
    logic [PAD_W-1:0]  s_pad, c_pad;
    logic [SEG_W-1:0]  seg_s, seg_c;
    logic [SEG_W:0]    seg_sum;

    xpb_csa32 #(.W(OUT_W)) u_csa (
        .a     (s_q),
        .b     (c_q),
        .c     (OUT_W'(in_data)),
        .sum   (csa_sum),
        .carry (csa_carry)
    );

    // Pad to whole segments so the last, partial segment reads zeros above OUT_W.
    assign s_pad = PAD_W'(s_q);
    assign c_pad = PAD_W'(c_q);

    always_comb begin
        seg_s = '0;
        seg_c = '0;
        for (int k = 0; k < NSEG; k++) begin
            if (seg_q == SIDX_W'(k)) begin
                seg_s = s_pad[k*SEG_W +: SEG_W];
                seg_c = c_pad[k*SEG_W +: SEG_W];
            end
        end
    end

    assign seg_sum = {1'b0, seg_s} + {1'b0, seg_c} + {{SEG_W{1'b0}}, carry_q};

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        c_d     = c_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        seg_d   = seg_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    s_d     = '0;
                    c_d     = '0;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    seg_d   = '0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    s_d   = csa_sum;
                    c_d   = csa_carry;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NUM_TERMS - 1)) state_d = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                for (int k = 0; k < NSEG; k++) begin
                    if (seg_q == SIDX_W'(k)) begin
                        for (int b = 0; b < SEG_W; b++) begin
                            if (k*SEG_W + b < OUT_W) out_d[k*SEG_W + b] = seg_sum[b];
                        end
                    end
                end
                carry_d = seg_sum[SEG_W];
                if (seg_q == SIDX_W'(NSEG - 1)) begin
                    seg_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    seg_d = seg_q + SIDX_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            c_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            seg_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = out_q;
    assign term_cnt  = cnt_q;

endmodule

// File: tb/tb_xpb_accum.sv
// Self-checking bench for xpb_accum: vector table, corner sequences and random runs vs. a big-integer sum.
module tb_xpb_accum;

    localparam int DATA_W    = 1024;
    localparam int NUM_TERMS = 32;
    localparam int SEG_W     = 128;
    localparam int CNT_W     = $clog2(NUM_TERMS + 1);
    localparam int OUT_W     = DATA_W + $clog2(NUM_TERMS);
    localparam int NSEG      = (OUT_W + SEG_W - 1) / SEG_W;
    localparam int LAT       = NSEG + 1;

    typedef logic [OUT_W-1:0] wide_t;
    typedef enum int {P_CONST, P_PAIR, P_INDEX, P_RAND} pat_e;
    typedef struct {
        pat_e              pat;
        logic [DATA_W-1:0] val;
        int                gap;
        wide_t             exp;
    } vec_t;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [OUT_W-1:0]  out_data;
    logic              out_ready;
    logic              busy;
    logic [CNT_W-1:0]  term_cnt;

    int total = 0;
    int bad   = 0;
    logic [DATA_W-1:0] terms [NUM_TERMS];
    wide_t last_out;
    vec_t  vecs [6];

    xpb_accum #(.DATA_W(DATA_W), .NUM_TERMS(NUM_TERMS), .SEG_W(SEG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .term_cnt  (term_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input wide_t act, input wide_t exp);
        int d;
        total++;
        if (act !== exp) begin
            bad++;
            d = -1;
            for (int i = OUT_W - 1; i >= 0; i--) if (d < 0 && act[i] !== exp[i]) d = i;
            $display("FAIL %s: got(low96)=%0h want(low96)=%0h highest_diff_bit=%0d",
                     nm, act[95:0], exp[95:0], d);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_word();
        logic [DATA_W-1:0] r;
        for (int b = 0; b < DATA_W / 32; b++) r[b*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic wide_t model_sum();
        wide_t acc;
        acc = '0;
        for (int i = 0; i < NUM_TERMS; i++) acc = acc + wide_t'(terms[i]);
        return acc;
    endfunction

    task automatic fill_terms(input pat_e pat, input logic [DATA_W-1:0] val);
        for (int i = 0; i < NUM_TERMS; i++) begin
            case (pat)
                P_CONST: terms[i] = val;
                P_PAIR:  terms[i] = (i == 0) ? val : ((i == 1) ? DATA_W'(1) : '0);
                P_INDEX: terms[i] = DATA_W'(i);
                default: terms[i] = rand_word();
            endcase
        end
    endtask

    // Runs one operation from IDLE; leaves the result in last_out and, if release_out, returns to IDLE.
    task automatic do_op(input string tag, input int gap, input bit release_out, input bit noisy);
        int idx, n, err, guard;
        bit v;
        err = 0;
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = noisy ? rand_word() : '1;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        chk({tag, " busy after start"}, wide_t'(busy), wide_t'(1));
        idx   = 0;
        guard = 0;
        while (idx < NUM_TERMS && guard < 1000) begin
            case (gap)
                0:       v = 1'b1;
                1:       v = (guard % 2 == 0);
                default: v = ($urandom_range(0, 1) == 1);
            endcase
            in_valid = v;
            in_data  = v ? terms[idx] : rand_word();
            if (noisy) start = ($urandom_range(0, 1) == 1);
            if (in_ready !== 1'b1 || term_cnt !== CNT_W'(idx)) err++;
            tick();
            if (v) idx++;
            guard++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk({tag, " in_ready/term_cnt errors in ACCUM"}, wide_t'(err), '0);
        chk({tag, " beats accepted"}, wide_t'(idx), wide_t'(NUM_TERMS));
        chk({tag, " in_ready after last beat"}, wide_t'(in_ready), '0);
        n = 1;
        while (out_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk({tag, " latency"}, wide_t'(n), wide_t'(LAT));
        chk({tag, " term_cnt in DONE"}, wide_t'(term_cnt), wide_t'(NUM_TERMS));
        last_out = out_data;
        if (release_out) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk({tag, " out_valid after handshake"}, wide_t'(out_valid), '0);
            chk({tag, " busy after handshake"}, wide_t'(busy), '0);
            chk({tag, " out_data held in IDLE"}, out_data, last_out);
        end
    endtask

    initial begin
        wide_t e;
        logic [DATA_W-1:0] v;
        int err;

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) tick();
        chk("reset busy", wide_t'(busy), '0);
        chk("reset in_ready", wide_t'(in_ready), '0);
        chk("reset out_valid", wide_t'(out_valid), '0);
        chk("reset term_cnt", wide_t'(term_cnt), '0);
        chk("reset out_data", out_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        vecs[0] = '{pat: P_CONST, val: DATA_W'(1), gap: 0, exp: wide_t'(32)};
        e = '1; e = e << 5;
        vecs[1] = '{pat: P_CONST, val: '1, gap: 0, exp: e};
        v = '0; v[127:0] = '1; e = '0; e[128] = 1'b1;
        vecs[2] = '{pat: P_PAIR, val: v, gap: 0, exp: e};
        v = '0; v[255:0] = '1; e = '0; e[256] = 1'b1;
        vecs[3] = '{pat: P_PAIR, val: v, gap: 0, exp: e};
        vecs[4] = '{pat: P_INDEX, val: '0, gap: 1, exp: wide_t'(496)};
        vecs[5] = '{pat: P_CONST, val: DATA_W'(1), gap: 2, exp: wide_t'(32)};

        for (int i = 0; i < 6; i++) begin
            fill_terms(vecs[i].pat, vecs[i].val);
            do_op($sformatf("row%0d", i), vecs[i].gap, 1'b1, 1'b0);
            chk($sformatf("row%0d out_data", i), last_out, vecs[i].exp);
        end

        // Backpressure in DONE with a stray start pulse.
        fill_terms(P_CONST, DATA_W'(3));
        do_op("bp", 0, 1'b0, 1'b0);
        chk("bp out_data", last_out, wide_t'(96));
        err = 0;
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'b0;
            start = (i == 2);
            if (out_valid !== 1'b1 || out_data !== last_out || in_ready !== 1'b0 || busy !== 1'b1) err++;
            tick();
        end
        start = 1'b0;
        chk("bp stall errors", wide_t'(err), '0);
        chk("bp still valid", wide_t'(out_valid), wide_t'(1));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp out_valid after release", wide_t'(out_valid), '0);
        chk("bp busy after release", wide_t'(busy), '0);
        chk("bp out_data kept", out_data, wide_t'(96));
        tick();
        chk("bp stray start ignored", wide_t'(busy), '0);

        // Abort mid-accumulation with an asynchronous reset.
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        in_data = DATA_W'(2);
        repeat (10) tick();
        in_valid = 1'b0;
        chk("abort term_cnt before reset", wide_t'(term_cnt), wide_t'(10));
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy", wide_t'(busy), '0);
        chk("abort in_ready", wide_t'(in_ready), '0);
        chk("abort term_cnt", wide_t'(term_cnt), '0);
        chk("abort out_data", out_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        fill_terms(P_CONST, DATA_W'(2));
        do_op("post_abort", 0, 1'b1, 1'b0);
        chk("post_abort out_data", last_out, wide_t'(64));

        for (int r = 0; r < 4; r++) begin
            fill_terms(P_RAND, '0);
            e = model_sum();
            do_op($sformatf("rand%0d", r), $urandom_range(0, 2), 1'b1, 1'b1);
            chk($sformatf("rand%0d out_data", r), last_out, e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
